instr_realign_buf: RTL and testbench

Parametrised fetch realigner with a halfword-parcel buffer, sitting between the IF stage and the instruction cache. It issues line-aligned fetches of FETCH_W bits, stores the returned 16-bit parcels in a small FIFO, and delivers one aligned instruction per cycle to IF. It handles 32-bit instructions that straddle fetch lines and restarts cleanly on redirect. It extends the single-word realigner to wider fetch and to a decoupling buffer.

---
 rtl/instr_realign_buf_pkg.sv | 23 ++
 rtl/ralgn_parcel_fifo.sv | 76 +++++++
 rtl/instr_realign_buf.sv | 165 ++++++++++++++++
 tb/tb_instr_realign_buf.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_realign_buf_pkg.sv
// ============================================================================
// instr_realign_buf_pkg
// Shared definitions for the fetch realigner and its parcel FIFO.
//   - RALGN_FETCH_W_DEF / RALGN_BUF_DEPTH_DEF : default line width / depth
//   - parcel_cnt_t                            : parcel counter wide enough for
//                                               any buffer up to RALGN_MAX_DEPTH
//   - type_ralgn_states_e                     : fetch-side FSM states
// ============================================================================
package instr_realign_buf_pkg;

   localparam int RALGN_FETCH_W_DEF   = 32;
   localparam int RALGN_BUF_DEPTH_DEF = 8;
   localparam int RALGN_MAX_DEPTH     = 64;

   // One extra bit so a completely full buffer can still be represented
   typedef logic [$clog2(RALGN_MAX_DEPTH):0] parcel_cnt_t;

   typedef enum logic {
      RALGN_IDLE  = 1'b0,
      RALGN_FETCH = 1'b1
   } type_ralgn_states_e;

endpackage

// File: rtl/ralgn_parcel_fifo.sv
// ============================================================================
// ralgn_parcel_fifo
// Circular buffer of 16-bit instruction parcels. A push writes up to PUSH_W
// parcels at once (parcel 0 of push_data_i lands first); a pop removes one or
// two parcels from the head. flush_i empties the buffer.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   flush_i        : discard all buffered parcels
//   push_i         : write push_n_i parcels from push_data_i
//   push_n_i       : number of parcels to write (0..PUSH_W)
//   push_data_i    : PUSH_W parcels, lowest parcel first
//   pop_i, pop2_i  : remove one parcel, or two when pop2_i is also set
//   count_o        : parcels currently stored
//   head_o, head1_o: oldest parcel and the one behind it
// ============================================================================
module ralgn_parcel_fifo
   import instr_realign_buf_pkg::*;
#(
   parameter int BUF_DEPTH = RALGN_BUF_DEPTH_DEF,
   parameter int PUSH_W    = 2
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush_i,
   input  logic                  push_i,
   input  parcel_cnt_t           push_n_i,
   input  logic [16*PUSH_W-1:0]  push_data_i,
   input  logic                  pop_i,
   input  logic                  pop2_i,
   output parcel_cnt_t           count_o,
   output logic [15:0]           head_o,
   output logic [15:0]           head1_o
);

   localparam int AW = $clog2(BUF_DEPTH);

   logic [15:0]   r_mem [BUF_DEPTH];
   logic [AW-1:0] r_rdPtr;
   logic [AW-1:0] r_wrPtr;
   parcel_cnt_t   r_count;
   parcel_cnt_t   w_popN;
   parcel_cnt_t   w_pushN;

   assign w_popN  = pop_i  ? (pop2_i ? parcel_cnt_t'(2) : parcel_cnt_t'(1)) : '0;
   assign w_pushN = push_i ? push_n_i : '0;

   // Pointer and occupancy bookkeeping; pointers wrap naturally because the
   // depth is a power of two.
   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         r_rdPtr <= '0;
         r_wrPtr <= '0;
         r_count <= '0;
      end else begin
         r_wrPtr <= r_wrPtr + AW'(w_pushN);
         r_rdPtr <= r_rdPtr + AW'(w_popN);
         r_count <= r_count + w_pushN - w_popN;
      end
   end

   // Parcel storage needs no reset: count gates every read that matters.
   always_ff @(posedge clk) begin
      if (push_i && !flush_i) begin
         for (int i = 0; i < PUSH_W; i++) begin
            if (parcel_cnt_t'(i) < push_n_i) begin
               r_mem[r_wrPtr + AW'(i)] <= push_data_i[16*i +: 16];
            end
         end
      end
   end

   assign count_o = r_count;
   assign head_o  = r_mem[r_rdPtr];
   assign head1_o = r_mem[r_rdPtr + AW'(1)];

endmodule

// File: rtl/instr_realign_buf.sv
// ============================================================================
// instr_realign_buf
// Fetch realigner: issues line-aligned cache reads of FETCH_W bits, buffers
// the returned parcels and hands one aligned instruction per cycle to IF.
// Optional feature macro: COMPRESSED_EN (16-bit instructions, halfword PCs).
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   if_req_i                 : IF allows new fetches
//   if_kill_i, if_pc_i       : redirect and its target PC
//   if_stall_i               : IF does not consume this cycle
//   if_valid_o, if_instr_o   : complete aligned instruction available
//   if_comp_o, if_pc_o       : instruction is 16-bit / its PC
//   ic_req_o, ic_addr_o      : cache request and line address
//   ic_kill_o                : abort outstanding cache request
//   ic_ack_i, ic_rdata_i     : cache response and line data
// ============================================================================
module instr_realign_buf
   import instr_realign_buf_pkg::*;
#(
   parameter int              FETCH_W   = RALGN_FETCH_W_DEF,
   parameter int              BUF_DEPTH = RALGN_BUF_DEPTH_DEF,
   parameter int              ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h8000_0000)
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               if_req_i,
   input  logic               if_kill_i,
   input  logic [ADDR_W-1:0]  if_pc_i,
   input  logic               if_stall_i,
   output logic               if_valid_o,
   output logic [31:0]        if_instr_o,
   output logic               if_comp_o,
   output logic [ADDR_W-1:0]  if_pc_o,
   output logic               ic_req_o,
   output logic [ADDR_W-1:0]  ic_addr_o,
   output logic               ic_kill_o,
   input  logic               ic_ack_i,
   input  logic [FETCH_W-1:0] ic_rdata_i
);

   localparam int PPL    = FETCH_W / 16;
   localparam int LB     = $clog2(FETCH_W / 8);
   localparam int SKIP_W = LB - 1;

   type_ralgn_states_e r_state;
   logic [ADDR_W-1:0]  r_fetchAddr;
   logic [ADDR_W-1:0]  r_headPc;
   logic [SKIP_W-1:0]  r_skip;

   parcel_cnt_t        w_count;
   parcel_cnt_t        w_pushN;
   logic [15:0]        w_head;
   logic [15:0]        w_head1;
   logic [FETCH_W-1:0] w_line;
   logic               w_comp;
   logic               w_valid;
   logic               w_pop;
   logic               w_push;
   logic               w_canIssue;
   logic               w_canIssueAfterAck;

   // Halfword PCs are only legal with compressed support; otherwise the
   // redirect target is forced onto a word boundary.
   function automatic logic [ADDR_W-1:0] normPc(input logic [ADDR_W-1:0] a);
`ifdef COMPRESSED_EN
      return a & ~ADDR_W'(1);
`else
      return a & ~ADDR_W'(3);
`endif
   endfunction

   function automatic logic [ADDR_W-1:0] alignLine(input logic [ADDR_W-1:0] a);
      return a & ~ADDR_W'(FETCH_W/8 - 1);
   endfunction

   function automatic logic [SKIP_W-1:0] skipOf(input logic [ADDR_W-1:0] a);
      logic [ADDR_W-1:0] n;
      n = normPc(a);
      return n[LB-1:1];
   endfunction

   // The first line after a restart drops the parcels that precede the target
   // PC; shifting them out lets the FIFO always take a contiguous low slice.
   assign w_line  = ic_rdata_i >> {r_skip, 4'b0000};
   assign w_pushN = parcel_cnt_t'(PPL) - parcel_cnt_t'(r_skip);
   assign w_push  = (r_state == RALGN_FETCH) && ic_ack_i && !if_kill_i;

   ralgn_parcel_fifo #(
      .BUF_DEPTH (BUF_DEPTH),
      .PUSH_W    (PPL)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (if_kill_i),
      .push_i      (w_push),
      .push_n_i    (w_pushN),
      .push_data_i (w_line),
      .pop_i       (w_pop),
      .pop2_i      (!w_comp),
      .count_o     (w_count),
      .head_o      (w_head),
      .head1_o     (w_head1)
   );

`ifdef COMPRESSED_EN
   assign w_comp = (w_head[1:0] != 2'b11);
`else
   assign w_comp = 1'b0;
`endif

   assign w_valid = (w_comp && (w_count >= parcel_cnt_t'(1))) || (w_count >= parcel_cnt_t'(2));
   assign w_pop   = w_valid && !if_stall_i && !if_kill_i;

   // Issue decisions ignore parcels popped this cycle. When a line lands, its
   // parcels are counted so the following request cannot overflow the buffer.
   assign w_canIssue         = if_req_i && ((32'(w_count) + 32'(PPL)) <= 32'(BUF_DEPTH));
   assign w_canIssueAfterAck = if_req_i &&
                               ((32'(w_count) + 32'(w_pushN) + 32'(PPL)) <= 32'(BUF_DEPTH));

   // Fetch FSM plus PC / fetch-address / skip registers. A redirect restarts
   // fetching straight away so the new line is requested in the next cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= RALGN_IDLE;
         r_fetchAddr <= alignLine(RESET_PC);
         r_headPc    <= normPc(RESET_PC);
         r_skip      <= skipOf(RESET_PC);
      end else if (if_kill_i) begin
         r_state     <= if_req_i ? RALGN_FETCH : RALGN_IDLE;
         r_fetchAddr <= alignLine(if_pc_i);
         r_headPc    <= normPc(if_pc_i);
         r_skip      <= skipOf(if_pc_i);
      end else begin
         if (w_pop) begin
            r_headPc <= r_headPc + (w_comp ? ADDR_W'(2) : ADDR_W'(4));
         end
         case (r_state)
            RALGN_IDLE: begin
               if (w_canIssue) begin
                  r_state <= RALGN_FETCH;
               end
            end
            RALGN_FETCH: begin
               if (ic_ack_i) begin
                  r_skip      <= '0;
                  r_fetchAddr <= r_fetchAddr + ADDR_W'(FETCH_W/8);
                  r_state     <= w_canIssueAfterAck ? RALGN_FETCH : RALGN_IDLE;
               end
            end
            default: r_state <= RALGN_IDLE;
         endcase
      end
   end

   // Outputs read as zero whenever there is nothing to present.
   assign if_valid_o = w_valid;
   assign if_comp_o  = w_valid && w_comp;
   assign if_instr_o = !w_valid ? 32'h0 : (w_comp ? {16'h0, w_head} : {w_head1, w_head});
   assign if_pc_o    = w_valid ? r_headPc : '0;
   assign ic_req_o   = (r_state == RALGN_FETCH);
   assign ic_addr_o  = ic_req_o ? r_fetchAddr : '0;
   assign ic_kill_o  = if_kill_i;

endmodule

// File: tb/tb_instr_realign_buf.sv
// ============================================================================
// tb_instr_realign_buf
// Drives the realigner (64-bit lines, 8-parcel buffer) with a cache model that
// serves lines from a random parcel image, and checks the delivered
// instruction stream against a program-order model of that image.
// ============================================================================
`timescale 1ns/1ps
module tb_instr_realign_buf;

   localparam int          FW     = 64;
   localparam int          BD     = 8;
   localparam logic [31:0] RST_PC = 32'h8000_0000;
`ifdef COMPRESSED_EN
   localparam bit COMP_EN = 1'b1;
`else
   localparam bit COMP_EN = 1'b0;
`endif

   logic          clk;
   logic          rst;
   logic          if_req;
   logic          if_kill;
   logic [31:0]   if_pc;
   logic          if_stall;
   logic          if_valid_o;
   logic [31:0]   if_instr_o;
   logic          if_comp_o;
   logic [31:0]   if_pc_o;
   logic          ic_req_o;
   logic [31:0]   ic_addr_o;
   logic          ic_kill_o;
   logic          ic_ack;
   logic [FW-1:0] ic_rdata;

   int total;
   int bad;

   // Program image: one parcel per halfword, 2 KiB window that wraps.
   logic [15:0] img [1024];

   // Reference model state
   logic [31:0] exp_pc;
   logic [31:0] exp_fetch;
   int          exp_skip;
   int          occ;
   int          occ_max;
   int          lat_cnt;
   int          lat_target;
   int          n_acks;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   instr_realign_buf #(
      .FETCH_W   (FW),
      .BUF_DEPTH (BD),
      .ADDR_W    (32),
      .RESET_PC  (RST_PC)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .if_req_i   (if_req),
      .if_kill_i  (if_kill),
      .if_pc_i    (if_pc),
      .if_stall_i (if_stall),
      .if_valid_o (if_valid_o),
      .if_instr_o (if_instr_o),
      .if_comp_o  (if_comp_o),
      .if_pc_o    (if_pc_o),
      .ic_req_o   (ic_req_o),
      .ic_addr_o  (ic_addr_o),
      .ic_kill_o  (ic_kill_o),
      .ic_ack_i   (ic_ack),
      .ic_rdata_i (ic_rdata)
   );

   function automatic logic [15:0] img_at(input logic [31:0] a);
      return img[a[10:1]];
   endfunction

   function automatic logic [63:0] line_at(input logic [31:0] a);
      return {img_at(a + 32'd6), img_at(a + 32'd4), img_at(a + 32'd2), img_at(a)};
   endfunction

   function automatic logic [31:0] norm_pc(input logic [31:0] a);
      return COMP_EN ? (a & ~32'h1) : (a & ~32'h3);
   endfunction

   // Instruction length in bytes at a given PC
   function automatic int inst_len(input logic [31:0] pc);
      logic [15:0] p;
      p = img_at(pc);
      return (COMP_EN && p[1:0] != 2'b11) ? 2 : 4;
   endfunction

   function automatic logic [31:0] inst_at(input logic [31:0] pc);
      if (inst_len(pc) == 2) return {16'h0, img_at(pc)};
      return {img_at(pc + 32'd2), img_at(pc)};
   endfunction

   task automatic set_parcel(input logic [31:0] a, input logic [15:0] v);
      img[a[10:1]] = v;
   endtask

   task automatic model_restart(input logic [31:0] pc);
      logic [31:0] n;
      n          = norm_pc(pc);
      exp_pc     = n;
      exp_fetch  = pc & ~32'h7;
      exp_skip   = int'(n[2:1]);
      occ        = 0;
      occ_max    = 0;
      lat_cnt    = 0;
      lat_target = 0;
   endtask

   // Runs traffic from a negedge: checks valid against buffered parcels, the
   // presented instruction against the image, and every fetch address.
   task automatic run_traffic(input int max_cycles, input int want, input int stall_pct,
                              input int max_lat);
      int          npop;
      int          len;
      logic [31:0] exp_i;
      logic        exp_v;
      npop   = 0;
      if_req = 1'b1;
      for (int c = 0; c < max_cycles && (want == 0 || npop < want); c++) begin
         len   = inst_len(exp_pc);
         exp_i = inst_at(exp_pc);
         exp_v = (occ >= len / 2);
         total++;
         if (if_valid_o !== exp_v) begin
            bad++;
            $display("[TB] FAIL valid at pc=%h: got %b want %b (parcels=%0d)",
                     exp_pc, if_valid_o, exp_v, occ);
         end
         if (if_valid_o === 1'b1) begin
            total++;
            if (if_pc_o !== exp_pc || if_instr_o !== exp_i || if_comp_o !== (len == 2)) begin
               bad++;
               $display("[TB] FAIL instr: got pc=%h instr=%h comp=%b want pc=%h instr=%h comp=%b",
                        if_pc_o, if_instr_o, if_comp_o, exp_pc, exp_i, (len == 2));
            end
         end
         if_stall = ($urandom_range(99) < stall_pct);
         if (exp_v && !if_stall) begin
            occ    -= len / 2;
            exp_pc += len;
            npop++;
         end
         ic_ack = 1'b0;
         if (ic_req_o === 1'b1) begin
            if (lat_cnt >= lat_target) begin
               total++;
               if (ic_addr_o !== exp_fetch) begin
                  bad++;
                  $display("[TB] FAIL fetch_addr: got %h want %h", ic_addr_o, exp_fetch);
               end
               ic_ack    = 1'b1;
               ic_rdata  = line_at(ic_addr_o);
               occ      += 4 - exp_skip;
               exp_skip  = 0;
               exp_fetch += 32'd8;
               n_acks++;
               if (occ > occ_max) occ_max = occ;
               lat_cnt    = 0;
               lat_target = int'($urandom_range(max_lat));
            end else begin
               lat_cnt++;
            end
         end
         @(negedge clk);
      end
      ic_ack = 1'b0;
      if (want != 0) begin
         total++;
         if (npop < want) begin
            bad++;
            $display("[TB] FAIL stream_timeout: got %0d instrs want %0d", npop, want);
         end
      end
      total++;
      if (occ_max > BD) begin
         bad++;
         $display("[TB] FAIL overflow: got %0d parcels want <= %0d", occ_max, BD);
      end
   endtask

   // Redirect from a negedge; optionally with a cache ack in the same cycle.
   task automatic do_kill(input logic [31:0] pc, input logic with_ack);
      if_kill  = 1'b1;
      if_pc    = pc;
      if_req   = 1'b1;
      if_stall = 1'($urandom_range(1));
      ic_ack   = with_ack;
      ic_rdata = line_at(ic_addr_o);
      #1;
      total++;
      if (ic_kill_o !== 1'b1) begin
         bad++;
         $display("[TB] FAIL ic_kill: got %b want 1", ic_kill_o);
      end
      @(negedge clk);
      if_kill = 1'b0;
      ic_ack  = 1'b0;
      model_restart(pc);
      total++;
      if (if_valid_o !== 1'b0 || ic_req_o !== 1'b1 || ic_addr_o !== (pc & ~32'h7)
          || ic_kill_o !== 1'b0) begin
         bad++;
         $display("[TB] FAIL after_kill: got valid=%b req=%b addr=%h kill=%b want 0 1 %h 0",
                  if_valid_o, ic_req_o, ic_addr_o, ic_kill_o, pc & ~32'h7);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; if_req = 1'b1; if_kill = 1'b0; if_stall = 1'b0;
      ic_ack = 1'b0; if_pc = 32'h0; ic_rdata = '0;
      @(negedge clk);
      @(negedge clk);
      total++; if (if_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL rst_valid: got %b want 0", if_valid_o); end
      total++; if (if_instr_o !== 32'h0) begin bad++; $display("[TB] FAIL rst_instr: got %h want 0", if_instr_o); end
      total++; if (if_comp_o !== 1'b0) begin bad++; $display("[TB] FAIL rst_comp: got %b want 0", if_comp_o); end
      total++; if (if_pc_o !== 32'h0) begin bad++; $display("[TB] FAIL rst_pc: got %h want 0", if_pc_o); end
      total++; if (ic_req_o !== 1'b0) begin bad++; $display("[TB] FAIL rst_req: got %b want 0", ic_req_o); end
      total++; if (ic_addr_o !== 32'h0) begin bad++; $display("[TB] FAIL rst_addr: got %h want 0", ic_addr_o); end
      total++; if (ic_kill_o !== 1'b0) begin bad++; $display("[TB] FAIL rst_kill: got %b want 0", ic_kill_o); end
      rst = 1'b0;
      model_restart(RST_PC);
   endtask

   // Line at RESET_PC holds four compressed-looking parcels; expect one
   // instruction per cycle right after the first ack.
   task automatic test_first_fetch();
      run_traffic(6, COMP_EN ? 4 : 2, 0, 0);
   endtask

   task automatic test_random_stream();
      run_traffic(800, 120, 25, 3);
   endtask

   task automatic test_stall_full();
      rst = 1'b1; if_req = 1'b0; ic_ack = 1'b0; if_stall = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_restart(RST_PC);
      n_acks = 0;
      run_traffic(20, 0, 100, 0);
      total++;
      if (n_acks !== 2) begin
         bad++;
         $display("[TB] FAIL stall_lines: got %0d want 2", n_acks);
      end
      total++;
      if (ic_req_o !== 1'b0) begin
         bad++;
         $display("[TB] FAIL stall_req: got %b want 0", ic_req_o);
      end
      run_traffic(400, 40, 20, 2);
   endtask

   task automatic test_kill_straddle();
      set_parcel(32'h8000_0106, 16'h0513);
      set_parcel(32'h8000_0108, 16'h0000);
      do_kill(32'h8000_0106, 1'b0);
      run_traffic(200, 20, 20, 2);
   endtask

   task automatic test_kill_with_ack();
      logic [31:0] tgt;
      do_kill(32'h8000_0040, 1'b0);
      tgt = 32'h8000_0000 + {21'h0, 10'($urandom_range(1023)), 1'b0};
      do_kill(tgt, 1'b1);
      run_traffic(300, 30, 20, 2);
   endtask

   task automatic test_kill_word();
      do_kill(32'h8000_0006, 1'b0);
      run_traffic(200, 20, 10, 1);
   endtask

   task automatic test_reset_midfetch();
      do_kill(32'h8000_0080, 1'b0);
      rst    = 1'b1;
      ic_ack = 1'b0;
      @(negedge clk);
      total++;
      if (ic_req_o !== 1'b0 || ic_addr_o !== 32'h0 || if_valid_o !== 1'b0
          || if_pc_o !== 32'h0 || if_instr_o !== 32'h0 || if_comp_o !== 1'b0) begin
         bad++;
         $display("[TB] FAIL midfetch_rst: got req=%b addr=%h valid=%b pc=%h want all 0",
                  ic_req_o, ic_addr_o, if_valid_o, if_pc_o);
      end
      rst = 1'b0;
      model_restart(RST_PC);
      run_traffic(300, 30, 10, 2);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      n_acks = 0;
      rst = 1'b1; if_req = 1'b0; if_kill = 1'b0; if_pc = 32'h0;
      if_stall = 1'b0; ic_ack = 1'b0; ic_rdata = '0;
      for (int i = 0; i < 1024; i++) img[i] = 16'($urandom);
      set_parcel(32'h8000_0000, 16'h4501);
      set_parcel(32'h8000_0002, 16'h4505);
      set_parcel(32'h8000_0004, 16'h4509);
      set_parcel(32'h8000_0006, 16'h450D);
      model_restart(RST_PC);

      test_reset();
      test_first_fetch();
      test_random_stream();
      test_stall_full();
      test_kill_straddle();
      test_kill_with_ack();
      test_kill_word();
      test_reset_midfetch();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
